// File: rtl/cpu_pkg.sv
// Shared core definitions: decoder op codes and the address width.
package cpu_pkg;

  localparam int ADDR_W = 8;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_JMP  = 3'd1,
    OP_BRZ  = 3'd2,
    OP_BRN  = 3'd3,
    OP_CALL = 3'd4,
    OP_RET  = 3'd5,
    OP_HALT = 3'd6,
    OP_RSVD = 3'd7
  } op_kind_t;

endpackage

// File: rtl/pc_seq_ret_stack.sv
// ret_stack: parameterised return-address LIFO; dout is the top entry,
// level counts occupied entries. Push on full and pop on empty are ignored.
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                       CLK,
  input  logic                       areset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int LW = $clog2(DEPTH + 1);

  // Sized to the full index range so the level-wide pointer indexes it exactly.
  logic [W-1:0]  mem [2**LW];
  logic [LW-1:0] top_idx;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign top_idx = level - LW'(1);
  assign dout    = mem[top_idx];

  // NOTE: only the pointer is reset; entries above level are never read, so
  // the storage needs no reset and can map onto plain registers or RAM.
  always_ff @(posedge CLK) begin
    if (areset) begin
      level <= '0;
    end else if (push && !full) begin
      mem[level] <= din;
      level      <= level + LW'(1);
    end else if (pop && !empty) begin
      level <= top_idx;
    end
  end

endmodule

// File: rtl/pc_seq.sv
// pc_seq: program-counter sequencer (jump/branch/call/return/halt, squash).
// Define PC_SEQ_STACK_EN to build the return-address stack.
module pc_seq
  import cpu_pkg::*;
#(
  parameter int STACK_DEPTH = 4
) (
  input  logic                               CLK,
  input  logic                               areset,
  input  logic                               op_valid,
  input  op_kind_t                           op_kind,
  input  logic [ADDR_W-1:0]                  op_target,
  input  logic                               flag_z,
  input  logic                               flag_n,
  input  logic [ADDR_W-1:0]                  pc_cur,
  output logic                               pc_write,
  output logic [ADDR_W-1:0]                  pc_next,
  output logic                               squash,
  output logic                               halted,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stk_level,
  output logic                               stk_err
);

  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

  state_t state, state_nxt;
  logic   err_set;
  logic   redirect;

`ifdef PC_SEQ_STACK_EN
  logic              push, pop, stk_full, stk_empty;
  logic [ADDR_W-1:0] stk_top, ret_addr;

  assign ret_addr = pc_cur + ADDR_W'(1);

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_ret_stack (
    .CLK    (CLK),
    .areset (areset),
    .push   (push),
    .pop    (pop),
    .din    (ret_addr),
    .dout   (stk_top),
    .full   (stk_full),
    .empty  (stk_empty),
    .level  (stk_level)
  );
`else
  assign stk_level = '0;
`endif

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    pc_write  = 1'b0;
    pc_next   = pc_cur;
    err_set   = 1'b0;
`ifdef PC_SEQ_STACK_EN
    push      = 1'b0;
    pc_next   = pc_cur;
    pop       = 1'b0;
`endif
    if (!areset) begin
      if (state == ST_HALT) begin
        pc_write = 1'b1;
      end else if (op_valid && !squash) begin
        case (op_kind)
          OP_JMP: begin
            pc_write = 1'b1;
            pc_next  = op_target;
          end
          OP_BRZ: begin
            pc_write = flag_z;
            pc_next  = op_target;
          end
          OP_BRN: begin
            pc_write = flag_n;
            pc_next  = op_target;
          end
          OP_CALL: begin
            pc_write = 1'b1;
            pc_next  = op_target;
`ifdef PC_SEQ_STACK_EN
            if (stk_full) err_set = 1'b1;
            else          push    = 1'b1;
`endif
          end
          OP_RET: begin
`ifdef PC_SEQ_STACK_EN
            if (stk_empty) begin
              err_set = 1'b1;
            end else begin
              pop      = 1'b1;
              pc_write = 1'b1;
              pc_next  = stk_top;
            end
`else
            err_set = 1'b1;
`endif
          end
          OP_HALT: begin
            pc_write  = 1'b1;
            state_nxt = ST_HALT;
          end
          default: ;
        endcase
      end
    end
  end

  // A halted core keeps writing pc_cur, which must not count as a redirect.
  assign redirect = pc_write && (state == ST_RUN);
  assign halted   = (state == ST_HALT);

  // NOTE: non-blocking assignments keep all state updates in this edge
  // independent of statement order.
  always_ff @(posedge CLK) begin
    if (areset) begin
      state   <= ST_RUN;
      squash  <= 1'b0;
      stk_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      squash  <= redirect;
      stk_err <= stk_err | err_set;
    end
  end

endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: directed test-plan steps then random ops, checked against a
// queue-based reference model of the sequencer rules.
module tb_pc_seq;
  import cpu_pkg::*;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);
`ifdef PC_SEQ_STACK_EN
  localparam bit STK_EN = 1'b1;
`else
  localparam bit STK_EN = 1'b0;
`endif

  logic           CLK = 1'b0;
  logic           areset;
  logic           op_valid;
  op_kind_t       op_kind;
  logic [7:0]     op_target;
  logic           flag_z, flag_n;
  logic [7:0]     pc_cur;
  logic           pc_write;
  logic [7:0]     pc_next;
  logic           squash, halted;
  logic [LW-1:0]  stk_level;
  logic           stk_err;

  pc_seq #(.STACK_DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .areset    (areset),
    .op_valid  (op_valid),
    .op_kind   (op_kind),
    .op_target (op_target),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .pc_cur    (pc_cur),
    .pc_write  (pc_write),
    .pc_next   (pc_next),
    .squash    (squash),
    .halted    (halted),
    .stk_level (stk_level),
    .stk_err   (stk_err)
  );

  always #5 CLK = ~CLK;

  // Reference model state
  bit         m_halt, m_squash, m_err;
  logic [7:0] m_stk[$];
  int         n_vec = 0;
  int         n_err = 0;

  // DUT values seen in the most recent cycle, for directed literal checks
  logic       obs_pw, obs_sq, obs_halt, obs_err;
  logic [7:0] obs_nx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit rst, input bit v, input op_kind_t k, input logic [7:0] tgt,
                       input logic [7:0] pc, input bit z, input bit nf);
    bit         pw, go_halt, do_push, do_pop, set_err;
    logic [7:0] nx;
    areset = rst; op_valid = v; op_kind = k; op_target = tgt;
    pc_cur = pc; flag_z = z; flag_n = nf;
    #1;
    pw = 0; nx = pc; go_halt = 0; do_push = 0; do_pop = 0; set_err = 0;
    if (rst) begin
      pw = 0;
    end else if (m_halt) begin
      pw = 1; nx = pc;
    end else if (v && !m_squash) begin
      case (k)
        OP_JMP:  begin pw = 1; nx = tgt; end
        OP_BRZ:  if (z)  begin pw = 1; nx = tgt; end
        OP_BRN:  if (nf) begin pw = 1; nx = tgt; end
        OP_CALL: begin
          pw = 1; nx = tgt;
          if (STK_EN) begin
            if (m_stk.size() < DEPTH) do_push = 1;
            else                      set_err = 1;
          end
        end
        OP_RET: begin
          if (STK_EN && m_stk.size() > 0) begin
            pw = 1; nx = m_stk[$]; do_pop = 1;
          end else begin
            set_err = 1;
          end
        end
        OP_HALT: begin pw = 1; nx = pc; go_halt = 1; end
        default: ;
      endcase
    end
    check("squash", squash, m_squash);
    check("halted", halted, m_halt);
    check("stk_level", stk_level, m_stk.size());
    check("stk_err", stk_err, m_err);
    check("pc_write", pc_write, pw);
    if (pw) check("pc_next", pc_next, nx);
    obs_pw = pc_write; obs_nx = pc_next; obs_sq = squash; obs_halt = halted; obs_err = stk_err;
    @(posedge CLK); #1;
    if (rst) begin
      m_halt = 0; m_squash = 0; m_err = 0; m_stk.delete();
    end else begin
      m_squash = pw && !m_halt;
      if (go_halt) m_halt = 1;
      if (set_err) m_err = 1;
      if (do_push) m_stk.push_back(pc + 8'd1);
      if (do_pop)  void'(m_stk.pop_back());
    end
  endtask

  task automatic idle(input logic [7:0] pc);
    cycle(0, 0, OP_NONE, 8'h00, pc, 0, 0);
  endtask

  initial begin
    areset = 1; op_valid = 0; op_kind = OP_NONE; op_target = 0;
    flag_z = 0; flag_n = 0; pc_cur = 0;
    repeat (2) @(posedge CLK);
    #1;
    m_halt = 0; m_squash = 0; m_err = 0; m_stk.delete();

    // Reset state, then NONE cycles
    cycle(1, 0, OP_NONE, 8'h00, 8'h00, 0, 0);
    check("rst_pw", obs_pw, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, OP_NONE, 8'h55, 8'(i), 1, 1);
      check("none_pw", obs_pw, 1'b0);
      check("none_sq", obs_sq, 1'b0);
    end

    // JMP, then a JMP ignored during squash
    cycle(0, 1, OP_JMP, 8'h40, 8'h10, 0, 0);
    check("jmp_pw", obs_pw, 1'b1);
    check("jmp_nx", obs_nx, 8'h40);
    cycle(0, 1, OP_JMP, 8'h99, 8'h40, 0, 0);
    check("sq_after_jmp", obs_sq, 1'b1);
    check("jmp_in_sq_pw", obs_pw, 1'b0);
    idle(8'h41);
    check("sq_one_cycle", obs_sq, 1'b0);

    // Conditional branches
    cycle(0, 1, OP_BRZ, 8'h20, 8'h42, 0, 1);
    check("brz_nt_pw", obs_pw, 1'b0);
    cycle(0, 1, OP_BRZ, 8'h20, 8'h43, 1, 0);
    check("brz_t_nx", obs_nx, 8'h20);
    idle(8'h20);
    cycle(0, 1, OP_BRN, 8'h30, 8'h21, 0, 1);
    check("brn_t_nx", obs_nx, 8'h30);
    idle(8'h30);

    // CALL / RET, and return-address wrap
    cycle(0, 1, OP_CALL, 8'h80, 8'h05, 0, 0);
    idle(8'h80);
    check("call_lvl", stk_level, STK_EN ? 1 : 0);
    cycle(0, 1, OP_RET, 8'h00, 8'h81, 0, 0);
    idle(8'h06);
    check("ret_lvl", stk_level, 0);
    cycle(0, 1, OP_CALL, 8'h10, 8'hFF, 0, 0);
    idle(8'h10);
    cycle(0, 1, OP_RET, 8'h00, 8'h11, 0, 0);
    idle(8'h00);

    // Overflow: five CALLs into a four-entry stack
    cycle(1, 0, OP_NONE, 8'h00, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, OP_CALL, 8'hA0 + 8'(i), 8'(i * 2), 0, 0);
      check("call_jump", obs_nx, 8'hA0 + 8'(i));
      idle(8'hA0 + 8'(i));
    end
    check("ovf_lvl", stk_level, STK_EN ? 4 : 0);
    check("ovf_err", stk_err, STK_EN ? 1 : 0);

    // Underflow: RET on an empty stack
    cycle(1, 0, OP_NONE, 8'h00, 8'h00, 0, 0);
    cycle(0, 1, OP_RET, 8'h00, 8'h08, 0, 0);
    check("unf_pw", obs_pw, 1'b0);
    idle(8'h09);
    check("unf_err", obs_err, 1'b1);

    // HALT with two stack entries, then reset during HALT
    cycle(1, 0, OP_NONE, 8'h00, 8'h00, 0, 0);
    cycle(0, 1, OP_CALL, 8'h31, 8'h01, 0, 0);
    idle(8'h31);
    cycle(0, 1, OP_CALL, 8'h33, 8'h32, 0, 0);
    idle(8'h33);
    cycle(0, 1, OP_HALT, 8'h00, 8'h33, 0, 0);
    check("halt_pw", obs_pw, 1'b1);
    check("halt_nx", obs_nx, 8'h33);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, OP_JMP, 8'h77, 8'h33, 1, 1);
      check("halted_hi", obs_halt, 1'b1);
      check("frozen_nx", obs_nx, 8'h33);
    end
    cycle(1, 1, OP_JMP, 8'h77, 8'h33, 0, 0);
    check("rst_in_halt_pw", obs_pw, 1'b0);
    idle(8'h00);
    check("post_rst_halt", obs_halt, 1'b0);
    check("post_rst_lvl", stk_level, 0);
    check("post_rst_err", obs_err, 1'b0);

    // Random ops against the model
    for (int i = 0; i < 600; i++) begin
      bit       r;
      op_kind_t k;
      r = ($urandom_range(0, 49) == 0) || (m_halt && $urandom_range(0, 5) == 0);
      k = op_kind_t'(3'($urandom_range(0, 7)));
      if (k == OP_HALT && $urandom_range(0, 7) != 0) k = OP_CALL;
      cycle(r, $urandom_range(0, 4) != 0, k, 8'($urandom), 8'($urandom),
            1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_seq.md
# pc_seq

Program-counter sequencer for the 8-bit core. It sits between the instruction decoder and the `pc` register and drives that register's `pc_write`/`addr_in` pair. It resolves jumps, conditional branches, call/return through an internal return-address stack, and halt. It also tells fetch to squash the one instruction fetched down the wrong path after every redirect.

## Interface
Parameters:
- `STACK_DEPTH`, default 4: number of return-address entries; must be ≥1.

Ports:
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `areset`  in  1  reset, synchronous and active-high.
- `op_valid`  in  1  decoder presents an op this cycle.
- `op_kind`  in  3  op code: 0 NONE, 1 JMP, 2 BRZ, 3 BRN, 4 CALL, 5 RET, 6 HALT, 7 reserved (treated as NONE).
- `op_target`  in  8  absolute target address for JMP, BRZ, BRN and CALL.
- `flag_z`  in  1  ALU zero flag.
- `flag_n`  in  1  ALU negative flag.
- `pc_cur`  in  8  current PC value, i.e. the address of the instruction the op belongs to.
- `pc_write`  out  1  load request to the PC register; when low, the PC self-increments.
- `pc_next`  out  8  load value for the PC register.
- `squash`  out  1  registered; fetch discards its current instruction.
- `halted`  out  1  registered; the core is stopped.
- `stk_level`  out  $clog2(STACK_DEPTH+1)  registered; number of occupied stack entries.
- `stk_err`  out  1  registered, sticky; a stack overflow or underflow has occurred.

## Operation
- FSM states: RUN and HALT. Reset enters RUN. HALT is left only through reset.
- An op is "effective" when the FSM is in RUN, `op_valid`=1 and `squash`=0. Otherwise the block behaves as if the op were NONE.
- `pc_write` and `pc_next` are combinational from the registered state and the current inputs.
- Effective op behaviour, per kind:
  - NONE or reserved: `pc_write`=0.
  - JMP: `pc_write`=1, `pc_next`=`op_target`.
  - BRZ: taken when `flag_z`=1. BRN: taken when `flag_n`=1. When taken, behave as JMP; when not taken, behave as NONE.
  - CALL: push `pc_cur`+1 (mod 256), then jump to `op_target`.
  - RET: pop; `pc_write`=1, `pc_next`=the popped entry.
  - HALT: `pc_write`=1, `pc_next`=`pc_cur`; FSM goes to HALT.
- In HALT: `pc_write`=1 and `pc_next`=`pc_cur` every cycle, so the PC is frozen.
- A "redirect" is any cycle with `pc_write`=1 while the FSM is in RUN. That includes HALT entry, which squashes the instruction fetched after it.
- Stack: LIFO with pointer `stk_level`; `stk_level` moves by at most 1 per cycle.
- CALL with a full stack: no push, the jump is still performed, `stk_err` is set.
- RET with an empty stack: treated as NONE, `stk_err` is set.
- `stk_err` clears only on reset.
- Reset in the middle of any operation: stack emptied, FSM to RUN, all registered outputs cleared. While `areset`=1, `pc_write`=0.

## Timing
- Decision has zero latency: `pc_write`/`pc_next` are valid in the same cycle as the op. The PC loads at the next edge.
- `squash` = redirect registered: high for exactly one cycle, immediately after a redirect cycle. Back-to-back redirects are impossible because an op is ignored while `squash`=1.
- `halted` rises the cycle after the HALT op.
- Stack push/pop and `stk_err` take effect at the edge that ends the op cycle.
- Reset values: `squash`=0, `halted`=0, `stk_level`=0, `stk_err`=0. `pc_write`=0 during reset.

## Configuration
- `PC_SEQ_STACK_EN` defined: behaviour as above.
- `PC_SEQ_STACK_EN` undefined:
  - No stack storage; `stk_level` is tied to 0.
  - CALL behaves as JMP and pushes nothing.
  - RET behaves as NONE and sets `stk_err`.

## Structure
- Shared package `cpu_pkg`: `op_kind_t` enum (the 3-bit codes above) and the `ADDR_W`=8 constant. The decoder and `pc_seq` both import it.
- One sub-module, `ret_stack`: a parameterised LIFO with inputs `push`, `pop`, `din` and outputs `dout` (the top entry), `full`, `empty`, `level`. It is instantiated only under `PC_SEQ_STACK_EN`.

## Test plan
- Reset, then 5 cycles of NONE → `pc_write`=0 throughout and `squash`=0.
- JMP to 0x40 at `pc_cur`=0x10 → `pc_write`=1 with `pc_next`=0x40; `squash`=1 on the next cycle; a JMP presented during that `squash` cycle is ignored.
- BRZ to 0x20 with `flag_z`=0 → `pc_write`=0. BRZ to 0x20 with `flag_z`=1 → `pc_next`=0x20. BRN to 0x30 with `flag_n`=1 → `pc_next`=0x30.
- CALL to 0x80 at `pc_cur`=0x05, then a later RET → `stk_level` goes 0→1→0 and RET gives `pc_next`=0x06. A CALL at `pc_cur`=0xFF pushes 0x00.
- 5 CALLs with `STACK_DEPTH`=4 → 5th CALL still jumps, `stk_err`=1, `stk_level`=4. RET on an empty stack → `pc_write`=0 and `stk_err`=1.
- HALT at 0x33 → `halted`=1 the next cycle and `pc_next`=0x33 held with `pc_write`=1. Reset asserted during HALT with 2 stack entries → all registered outputs 0 after the edge.
